// File: rtl/instr_fetch.sv
// Instruction fetch/issue stage: reads 20-bit words from a synchronous instruction
// memory, issues one op pulse per valid word and waits for the controller's acc_load.
module instr_fetch #(
  parameter int          ADDR_W       = 8,
  parameter int          EXEC_TIMEOUT = 4,
  parameter logic [3:0]  HALT_OP      = 4'b1111
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [19:0]       imem_data,
  input  logic              acc_load,
  output logic [3:0]        opcode,
  output logic [7:0]        operand_b,
  output logic [7:0]        operand_a,
  output logic              op,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic              fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam int CNT_W = $clog2(EXEC_TIMEOUT + 1);

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [19:0]       ir_reg, ir_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              op_reg, op_next;
  logic              rd_en_reg, rd_en_next;
  logic              illegal_reg, illegal_next;
  logic              fault_reg, fault_next;

  logic [3:0] fetched_op;
  logic       fetched_illegal;

  assign fetched_op      = imem_data[19:16];
  assign fetched_illegal = (fetched_op >= 4'd9) && (fetched_op <= 4'd14);

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    cnt_next     = cnt_reg;
    illegal_next = illegal_reg;
    fault_next   = fault_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        state_next = S_LATCH;
      end
      S_LATCH: begin
        ir_next = imem_data;
        if (fetched_op == HALT_OP) begin
          state_next = S_HALTED;
        end else if (fetched_illegal) begin
          illegal_next = 1'b1;
          pc_next      = pc_reg + ADDR_W'(1);
          state_next   = S_FETCH;
        end else begin
          pc_next    = pc_reg + ADDR_W'(1);
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_next   = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // completion wins over a watchdog expiring in the same cycle
        if (acc_load) begin
          state_next = S_FETCH;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(EXEC_TIMEOUT - 1)) begin
            fault_next = 1'b1;
            state_next = S_HALTED;
          end
        end
      end
      S_HALTED: begin
        if (start) begin
          pc_next      = '0;
          illegal_next = 1'b0;
          fault_next   = 1'b0;
          state_next   = S_FETCH;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // op and read enable are registered, so they are decoded from the next state
    op_next    = (state_next == S_ISSUE);
    rd_en_next = (state_next == S_FETCH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      pc_reg      <= '0;
      ir_reg      <= '0;
      cnt_reg     <= '0;
      op_reg      <= 1'b0;
      rd_en_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      fault_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      cnt_reg     <= cnt_next;
      op_reg      <= op_next;
      rd_en_reg   <= rd_en_next;
      illegal_reg <= illegal_next;
      fault_reg   <= fault_next;
    end
  end

  assign imem_addr  = pc_reg;
  assign imem_rd_en = rd_en_reg;
  assign opcode     = ir_reg[19:16];
  assign operand_b  = ir_reg[15:8];
  assign operand_a  = ir_reg[7:0];
  assign op         = op_reg;
  assign pc         = pc_reg;
  assign busy       = (state_reg != S_IDLE) && (state_reg != S_HALTED);
  assign halted     = (state_reg == S_HALTED);
  assign illegal    = illegal_reg;
  assign fault      = fault_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-walking reference model queues the
// expected op transactions; a monitor pops and compares them as op pulses appear.
module tb_instr_fetch;

  localparam int         AW  = 8;
  localparam int         TMO = 4;
  localparam logic [3:0] HOP = 4'hF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          acc_load = 1'b0;
  logic [AW-1:0] imem_addr, pc;
  logic          imem_rd_en;
  logic [19:0]   imem_data = 20'h0;
  logic [3:0]    opcode;
  logic [7:0]    operand_a, operand_b;
  logic          op, busy, halted, illegal, fault;

  // second instance with a 2-bit PC to exercise wrap-around
  logic          reset2_n = 1'b0;
  logic          start2 = 1'b0;
  logic          acc_load2 = 1'b0;
  logic [1:0]    imem_addr2, pc2;
  logic          imem_rd_en2;
  logic [19:0]   imem_data2 = 20'h0;
  logic [3:0]    opcode2;
  logic [7:0]    operand_a2, operand_b2;
  logic          op2, busy2, halted2, illegal2, fault2;

  instr_fetch #(.ADDR_W(AW), .EXEC_TIMEOUT(TMO), .HALT_OP(HOP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_data(imem_data),
    .acc_load(acc_load), .opcode(opcode), .operand_b(operand_b), .operand_a(operand_a),
    .op(op), .pc(pc), .busy(busy), .halted(halted), .illegal(illegal), .fault(fault)
  );

  instr_fetch #(.ADDR_W(2), .EXEC_TIMEOUT(TMO), .HALT_OP(HOP)) dut2 (
    .clk(clk), .reset_n(reset2_n), .start(start2),
    .imem_addr(imem_addr2), .imem_rd_en(imem_rd_en2), .imem_data(imem_data2),
    .acc_load(acc_load2), .opcode(opcode2), .operand_b(operand_b2), .operand_a(operand_a2),
    .op(op2), .pc(pc2), .busy(busy2), .halted(halted2), .illegal(illegal2), .fault(fault2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] opc;
    logic [7:0] b;
    logic [7:0] a;
    int         pc_after;
    int         gap;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp2_q[$];
  logic [19:0] mem  [0:255];
  logic [19:0] mem2 [0:3];

  int total = 0;
  int bad = 0;
  bit ctrl_en = 1'b1;
  int op_count = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(posedge clk) if (imem_rd_en)  imem_data  <= mem[imem_addr];
  always @(posedge clk) if (imem_rd_en2) imem_data2 <= mem2[imem_addr2];

  // monitor + controller model for the main instance
  int          cyc = 0, last_op_cyc = 0, pend = 0;
  bit          in_exec = 1'b0, prev_op = 1'b0;
  logic [19:0] held;
  exp_t        e_mon;
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      in_exec = 1'b0;
      prev_op = 1'b0;
      pend = 0;
      acc_load = 1'b0;
    end else begin
      if (prev_op) check("op_single_cycle", op, 0);
      if (halted || !busy) in_exec = 1'b0;
      if (in_exec) begin
        check("ir_stable_until_acc_load", {opcode, operand_b, operand_a}, held);
        if (acc_load) in_exec = 1'b0;
      end
      if (op) begin
        op_count++;
        $display("op: opcode=%0h b=%02h a=%02h pc=%0d", opcode, operand_b, operand_a, pc);
        if (exp_q.size() == 0) begin
          check("unexpected_op", op, 0);
        end else begin
          e_mon = exp_q.pop_front();
          check("op_opcode", opcode, e_mon.opc);
          check("op_operand_b", operand_b, e_mon.b);
          check("op_operand_a", operand_a, e_mon.a);
          check("op_pc", pc, e_mon.pc_after);
          if (e_mon.gap > 0) check("op_gap", cyc - last_op_cyc, e_mon.gap);
        end
        last_op_cyc = cyc;
        held = {opcode, operand_b, operand_a};
        in_exec = 1'b1;
      end
      prev_op = op;
      // controller responds with acc_load two cycles after op
      acc_load = 1'b0;
      if (op && ctrl_en) pend = 2;
      else if (pend > 0) begin
        if (pend == 1) acc_load = 1'b1;
        pend--;
      end
    end
  end

  // monitor + controller model for the wrap instance
  int   cyc2 = 0, last_op_cyc2 = 0, pend2 = 0;
  exp_t e_mon2;
  always @(negedge clk) begin
    cyc2++;
    if (!reset2_n) begin
      pend2 = 0;
      acc_load2 = 1'b0;
    end else begin
      if (op2 && exp2_q.size() > 0) begin
        $display("op2: opcode=%0h a=%02h pc=%0d", opcode2, operand_a2, pc2);
        e_mon2 = exp2_q.pop_front();
        check("wrap_opcode", opcode2, e_mon2.opc);
        check("wrap_operand_a", operand_a2, e_mon2.a);
        check("wrap_pc", pc2, e_mon2.pc_after);
        if (e_mon2.gap > 0) check("wrap_gap", cyc2 - last_op_cyc2, e_mon2.gap);
        last_op_cyc2 = cyc2;
      end
      acc_load2 = 1'b0;
      if (op2) pend2 = 2;
      else if (pend2 > 0) begin
        if (pend2 == 1) acc_load2 = 1'b1;
        pend2--;
      end
    end
  end

  // Walks the program from address 0 by the fetch rules and queues every issued op.
  task automatic model(output int fpc, output bit fill);
    int   p = 0, skipped = 0;
    bit   first = 1'b1;
    exp_t e;
    fill = 1'b0;
    for (int s = 0; s < 600; s++) begin
      if (mem[p][19:16] == HOP) break;
      if (mem[p][19:16] >= 4'd9) begin
        fill = 1'b1;
        skipped++;
      end else begin
        e.opc = mem[p][19:16];
        e.b = mem[p][15:8];
        e.a = mem[p][7:0];
        e.pc_after = (p + 1) % 256;
        e.gap = first ? -1 : 5 + 2 * skipped;
        first = 1'b0;
        skipped = 0;
        exp_q.push_back(e);
      end
      p = (p + 1) % 256;
    end
    fpc = p;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = {HOP, 16'h0000};
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fetch_rd_en", imem_rd_en, 1);
    check("fetch_addr", imem_addr, 0);
    check("fetch_busy", busy, 1);
    check("fetch_illegal_clear", illegal, 0);
    check("fetch_fault_clear", fault, 0);
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
    check("halt_reached", halted, 1);
  endtask

  task automatic wait_op();
    for (int i = 0; i < 50 && !op; i++) @(negedge clk);
    check("op_seen", op, 1);
  endtask

  task automatic run_prog();
    int fpc;
    bit fill;
    model(fpc, fill);
    pulse_start();
    wait_halt();
    check("final_pc", pc, fpc);
    check("final_illegal", illegal, fill);
    check("final_fault", fault, 0);
    check("final_opcode_is_halt", opcode, HOP);
    check("final_busy", busy, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_op", op, 0);
    check("rst_rd_en", imem_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_fault", fault, 0);
    check("rst_pc", pc, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_ir", {opcode, operand_b, operand_a}, 0);
  endtask

  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1 check_reset_vals();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int fpc, n, cnt_before, k;
    bit fill;
    logic [3:0] o;
    clear_mem();
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_without_start", busy, 0);

    // single add then halt
    clear_mem();
    mem[0] = 20'h0_0503;
    mem[1] = 20'hF_0000;
    run_prog();

    // three valid ops back to back
    clear_mem();
    mem[0] = {4'h1, 16'($urandom)};
    mem[1] = {4'h3, 16'($urandom)};
    mem[2] = {4'h8, 16'($urandom)};
    run_prog();

    // illegal word skipped
    clear_mem();
    mem[0] = 20'hA_1234;
    mem[1] = 20'h0_0201;
    run_prog();

    // random programs, illegal and valid opcodes mixed
    for (int r = 0; r < 6; r++) begin
      clear_mem();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        o = 4'($urandom_range(0, 14));
        mem[i] = {o, 16'($urandom)};
      end
      run_prog();
    end

    // watchdog: controller never completes
    clear_mem();
    mem[0] = 20'h2_1122;
    ctrl_en = 1'b0;
    model(fpc, fill);
    pulse_start();
    wait_op();
    k = 0;
    while (!halted && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", k, TMO + 1);
    check("timeout_fault", fault, 1);
    check("timeout_halted", halted, 1);
    check("timeout_pc", pc, 1);
    ctrl_en = 1'b1;
    run_prog();

    // reset during WAIT_EXEC
    ctrl_en = 1'b0;
    model(fpc, fill);
    pulse_start();
    wait_op();
    @(negedge clk);
    reset_pulse();
    ctrl_en = 1'b1;
    cnt_before = op_count;
    repeat (10) @(negedge clk);
    check("no_op_after_reset_wait", op_count, cnt_before);
    check("idle_after_reset_wait", busy, 0);

    // reset during LATCH
    model(fpc, fill);
    pulse_start();
    @(negedge clk);
    reset_pulse();
    cnt_before = op_count;
    repeat (10) @(negedge clk);
    check("no_op_after_reset_latch", op_count, cnt_before);
    run_prog();

    // 2-bit PC wrap: no halt, fetch continues past address 3
    for (int i = 0; i < 4; i++) mem2[i] = {4'(i * 2), 8'h5A, 8'(i)};
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.opc = 4'((i % 4) * 2);
      e.b = 8'h5A;
      e.a = 8'(i % 4);
      e.pc_after = (i + 1) % 4;
      e.gap = (i == 0) ? -1 : 5;
      exp2_q.push_back(e);
    end
    reset2_n = 1'b1;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 200 && exp2_q.size() > 0; i++) @(negedge clk);
    check("wrap_queue_drained", exp2_q.size(), 0);
    check("wrap_still_busy", busy2, 1);
    reset2_n = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch/issue stage directly upstream of the ALU/accumulator controller.
- Reads 20-bit instruction words [opcode 4][operand B 8][operand A 8] from a synchronous instruction memory and holds them in an instruction register (IR).
- Presents opcode/operands and a one-cycle `op` start pulse to the controller, then waits for the controller's `acc_load` completion strobe before fetching the next word.
- Also handles program-counter sequencing, illegal-opcode skipping, halt, and an execute watchdog.

Parameters:
ADDR_W, 8, instruction memory address width; PC wraps modulo 2^ADDR_W
EXEC_TIMEOUT, 4, max cycles in WAIT_EXEC without acc_load before fault (>=3)
HALT_OP, 4'b1111, opcode that stops fetching

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin/restart execution
imem_addr  out  ADDR_W  instruction memory address (= pc)
imem_rd_en  out  1  memory read enable; data valid on imem_data the following cycle
imem_data  in  20  instruction word
acc_load  in  1  controller completion strobe (high in controller execute cycle)
opcode  out  4  IR[19:16] to controller
operand_b  out  8  IR[15:8]
operand_a  out  8  IR[7:0]
op  out  1  one-cycle instruction start pulse to controller
pc  out  ADDR_W  program counter
busy  out  1  high in any state except IDLE/HALTED
halted  out  1  high in HALTED
illegal  out  1  sticky: an opcode 9..14 was fetched and skipped
fault  out  1  sticky: execute watchdog expired

Behaviour:
- Reset (reset_n low, async): state=IDLE; pc, IR, timeout counter = 0; op, imem_rd_en, busy, halted, illegal, fault = 0. Reset mid-instruction aborts immediately; no op is issued after release until start.
- Interface and state transitions:
  - All outputs are registered, except imem_addr (= pc) and busy/halted (decoded from state).
  - States: IDLE, FETCH, LATCH, ISSUE, WAIT_EXEC, HALTED.
  - IDLE: wait for start -> FETCH.
  - FETCH: imem_rd_en=1 for exactly this cycle, imem_addr=pc -> LATCH.
  - LATCH: IR <= imem_data. Then:
    - opcode == HALT_OP -> HALTED, pc unchanged (points at halt word).
    - opcode 9..14 -> illegal<=1, pc<=pc+1 -> FETCH (no op issued).
    - opcode 0..8 -> pc<=pc+1 -> ISSUE.
  - ISSUE: op=1 for exactly this one cycle; clear timeout counter -> WAIT_EXEC.
  - WAIT_EXEC: op=0; IR held stable. The controller decodes opcode in the cycle after op, so IR must not change until completion.
    - acc_load=1 -> FETCH on next edge.
    - Otherwise increment counter; when it reaches EXEC_TIMEOUT -> fault<=1, HALTED.
  - HALTED: op=0, imem_rd_en=0. start -> clear pc, illegal, fault -> FETCH. Only reset or start leaves HALTED.
- start while busy is ignored. acc_load outside WAIT_EXEC is ignored.
- Nominal timing:
  - ISSUE at cycle t, controller decode at t+1, acc_load at t+2, FETCH at t+3.
  - Throughput is 5 cycles per valid instruction, 2 cycles per skipped illegal word.
- PC wraps from 2^ADDR_W-1 to 0 without flagging.
- op must never be high on two consecutive cycles. IR/opcode/operands change only in LATCH.
- illegal and fault are sticky until reset or start-from-HALTED.

Test Plan:
- Reset then start, imem[0]=20'h0_0503 (add A=3,B=5), imem[1]=20'hF_0000 -> imem_rd_en at cycle 1, op one cycle with opcode=0/operand_a=8'h03/operand_b=8'h05; acc_load at op+2 -> FETCH of addr 1; halted=1, pc=1.
- Program of 3 valid ops (0x1, 0x3, 0x8) then halt, controller model responding -> exactly 3 op pulses 5 cycles apart; opcode stable from each op until its acc_load.
- imem[0]=20'hA_1234, imem[1]=add, imem[2]=halt -> no op for word 0, illegal=1; op issued for word 1; halted with pc=2.
- Controller model never asserts acc_load -> fault=1 and HALTED exactly EXEC_TIMEOUT cycles after the WAIT_EXEC entry; start -> fault=0, pc=0, fetch restarts.
- ADDR_W=2, memory filled with valid ops, no halt -> pc sequence 0,1,2,3,0; fetch continues after wrap.
- reset_n asserted during WAIT_EXEC and during LATCH -> all outputs return to reset values asynchronously; no op pulse until the next start.
